// File: rtl/imem_fetch_queue.sv
// Instruction fetch: word-addressed imem with a synchronous read port, a load port, and a prefetch FIFO.
// Latency: an issue at edge N is pushed at N+1 and is visible as the head after N+1; 1 instr/cycle sustained.
// Backpressure: issue stalls while queued + in-flight would exceed DEPTH; entries are never dropped except on redirect or reset.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   load_en_i/load_addr_i/load_data_i  program-load write port (word addressed)
//   redirect_i/redirect_pc_i         flush the queue and restart fetch at a new byte PC
//   inst_valid_o/inst_ready_i        handshake towards decode
//   inst_o/inst_pc_o                 head instruction and its byte PC (0 when not valid)
module imem_fetch_queue #(
    parameter int          ADDR_W   = 11,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              inst_ready_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [31:0]       inst_pc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [31:0]       tag_pc_q;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] fifo_inst_q [0:DEPTH-1];
    logic [31:0]       fifo_pc_q   [0:DEPTH-1];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] rd_idx;

    // The index is a slice of the PC, so the memory wraps while the PC keeps counting.
    assign rd_idx = fetch_pc_q[ADDR_W+1:2];

    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_valid_o ? fifo_inst_q[rd_ptr_q] : '0;
    assign inst_pc_o    = inst_valid_o ? fifo_pc_q[rd_ptr_q]   : '0;

    assign pop  = inst_valid_o && inst_ready_i;
    // A return landing on a redirect cycle belongs to the old stream and is dropped.
    assign push = inflight_q && !redirect_i;

    // Slots committed after this edge: a read is only launched if its return is guaranteed a slot.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    // Blocking reads during loads keeps the single memory port free of read/write collisions.
    assign issue = !rst_i && !redirect_i && !load_en_i && (occupancy < (CNT_W+1)'(DEPTH));

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inflight_d = issue;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)  wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Datapath storage carries no reset; validity is tracked entirely by count_q/inflight_q.
    always_ff @(posedge clk_i) begin
        if (load_en_i) mem_q[load_addr_i] <= load_data_i;
        if (issue) begin
            rd_data_q <= mem_q[rd_idx];
            tag_pc_q  <= fetch_pc_q;
        end
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= rd_data_q;
            fifo_pc_q[wr_ptr_q]   <= tag_pc_q;
        end
    end

endmodule

// File: tb/tb_imem_fetch_queue.sv
module tb_imem_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [10:0] load_addr;
    logic [31:0] load_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int errors = 0;
    int checks = 0;

    imem_fetch_queue dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_en_i    (load_en),
        .load_addr_i  (load_addr),
        .load_data_i  (load_data),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .inst_ready_i (inst_ready),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_pc_o    (inst_pc)
    );

    always #5 clk = ~clk;

    // Memory image written by the bench: words 0..2 from the program example, the rest tagged by index.
    function automatic logic [31:0] exp_word(input int idx);
        if (idx < 3) return 32'h1111_1111 * (idx + 1);
        return 32'hA000_0000 | idx;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    task automatic test_reset;
        tick();
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", inst_pc); end
    endtask

    // Fill the whole memory while reset is held; the write port is independent of reset.
    task automatic load_program;
        for (int i = 0; i < 2048; i++) begin
            load_en   = 1'b1;
            load_addr = 11'(i);
            load_data = exp_word(i);
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic test_first_fetch;
        rst = 1'b0;
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL first_e0_valid: got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL first_e1_valid: got %b expected 1", inst_valid); end
        checks++; if (inst_pc !== 32'h0040_0000) begin errors++; $display("FAIL first_pc: got %h expected 00400000", inst_pc); end
        checks++; if (inst !== 32'h1111_1111) begin errors++; $display("FAIL first_inst: got %h expected 11111111", inst); end
    endtask

    task automatic test_backpressure;
        inst_ready = 1'b0;
        repeat (10) tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b expected 1", inst_valid); end
        checks++; if (inst_pc !== 32'h0040_0000) begin errors++; $display("FAIL bp_hold_pc: got %h expected 00400000", inst_pc); end
        // Four queued entries drain first, then the refetch continues without a gap or a skipped PC.
        inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %b expected 1", k, inst_valid); end
            checks++; if (inst_pc !== 32'h0040_0000 + 32'(4*k)) begin errors++; $display("FAIL bp_drain_pc[%0d]: got %h expected %h", k, inst_pc, 32'h0040_0000 + 32'(4*k)); end
            checks++; if (inst !== exp_word(k)) begin errors++; $display("FAIL bp_drain_inst[%0d]: got %h expected %h", k, inst, exp_word(k)); end
            tick();
        end
    endtask

    task automatic test_redirect_basic;
        logic [31:0] exp_i [3];
        exp_i[0] = 32'h1111_1111;
        exp_i[1] = 32'h2222_2222;
        exp_i[2] = 32'h3333_3333;
        inst_ready = 1'b1;
        do_redirect(32'h0000_0000);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_r_valid: got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_r1_valid: got %b expected 0", inst_valid); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL redir_valid[%0d]: got %b expected 1", k, inst_valid); end
            checks++; if (inst_pc !== 32'(4*k)) begin errors++; $display("FAIL redir_pc[%0d]: got %h expected %h", k, inst_pc, 32'(4*k)); end
            checks++; if (inst !== exp_i[k]) begin errors++; $display("FAIL redir_inst[%0d]: got %h expected %h", k, inst, exp_i[k]); end
            tick();
        end
    endtask

    task automatic test_redirect_flush;
        inst_ready = 1'b0;
        do_redirect(32'h0000_0100);
        // After four more edges: three entries queued and the fourth read in flight.
        repeat (4) tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", inst_valid); end
        checks++; if (inst_pc !== 32'h0000_0100) begin errors++; $display("FAIL flush_pre_pc: got %h expected 00000100", inst_pc); end
        do_redirect(32'h0000_0040);
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_valid: got %b expected 0", inst_valid); end
        inst_ready = 1'b1;
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL flush_stale_valid: got %b expected 0", inst_valid); end
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL flush_valid[%0d]: got %b expected 1", k, inst_valid); end
            checks++; if (inst_pc !== 32'h40 + 32'(4*k)) begin errors++; $display("FAIL flush_pc[%0d]: got %h expected %h", k, inst_pc, 32'h40 + 32'(4*k)); end
            checks++; if (inst !== exp_word(16 + k)) begin errors++; $display("FAIL flush_inst[%0d]: got %h expected %h", k, inst, exp_word(16 + k)); end
            tick();
        end
    endtask

    task automatic test_load_during_fetch;
        logic [31:0] exp_pc;
        int bubbles;
        inst_ready = 1'b1;
        do_redirect(32'h0000_0200);
        tick();
        tick();
        exp_pc  = 32'h0000_0200;
        bubbles = 0;
        for (int k = 0; k < 8; k++) begin
            if (inst_valid === 1'b1) begin
                checks++; if (inst_pc !== exp_pc) begin errors++; $display("FAIL load_seq_pc[%0d]: got %h expected %h", k, inst_pc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
            end else begin
                bubbles++;
            end
            load_en   = (k == 0);
            load_addr = 11'd5;
            load_data = 32'h55AA_55AA;
            tick();
        end
        load_en = 1'b0;
        checks++; if (bubbles != 1) begin errors++; $display("FAIL load_bubbles: got %0d expected 1", bubbles); end
        checks++; if (exp_pc !== 32'h0000_021C) begin errors++; $display("FAIL load_delivered_next_pc: got %h expected 0000021c", exp_pc); end
        do_redirect(32'h0000_0014);
        tick();
        tick();
        checks++; if (inst_pc !== 32'h0000_0014) begin errors++; $display("FAIL load_readback_pc: got %h expected 00000014", inst_pc); end
        checks++; if (inst !== 32'h55AA_55AA) begin errors++; $display("FAIL load_readback_inst: got %h expected 55aa55aa", inst); end
    endtask

    task automatic test_wrap;
        inst_ready = 1'b1;
        do_redirect(32'h0040_1FFC);
        tick();
        tick();
        checks++; if (inst_pc !== 32'h0040_1FFC) begin errors++; $display("FAIL wrap_last_pc: got %h expected 00401ffc", inst_pc); end
        checks++; if (inst !== exp_word(2047)) begin errors++; $display("FAIL wrap_last_inst: got %h expected %h", inst, exp_word(2047)); end
        tick();
        checks++; if (inst_pc !== 32'h0040_2000) begin errors++; $display("FAIL wrap_next_pc: got %h expected 00402000", inst_pc); end
        checks++; if (inst !== exp_word(0)) begin errors++; $display("FAIL wrap_next_inst: got %h expected %h", inst, exp_word(0)); end
    endtask

    task automatic test_reset_mid;
        inst_ready = 1'b1;
        repeat (3) tick();
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b expected 1", inst_valid); end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rmid_async_inst: got %h expected 0", inst); end
        checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rmid_async_pc: got %h expected 0", inst_pc); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rmid_e0_valid: got %b expected 0", inst_valid); end
        tick();
        checks++; if (inst_pc !== 32'h0040_0000) begin errors++; $display("FAIL rmid_first_pc: got %h expected 00400000", inst_pc); end
        checks++; if (inst !== 32'h1111_1111) begin errors++; $display("FAIL rmid_first_inst: got %h expected 11111111", inst); end
    endtask

    initial begin
        rst         = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        test_reset();
        load_program();
        test_first_fetch();
        test_backpressure();
        test_redirect_basic();
        test_redirect_flush();
        test_load_during_fetch();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
